// File: rtl/l2_backing_memory.sv
// Block-granular main-memory responder behind the L2: one block per access after a fixed
// latency, with a single open-row buffer that shortens the latency for repeat blocks.
module l2_backing_memory #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BLOCK_SIZE   = 16,
    parameter int MEM_BLOCKS   = 256,
    parameter int MISS_LATENCY = 20,
    parameter int HIT_LATENCY  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_wdata,
    input  logic                                  mem_read,
    input  logic                                  mem_write,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_rdata,
    output logic                                  mem_ready,
    output logic                                  mem_hit,
    output logic                                  mem_busy
);

    localparam int OFF  = $clog2(BLOCK_SIZE);
    localparam int BIDX = $clog2(MEM_BLOCKS);
    localparam int CW   = $clog2(MISS_LATENCY + 1);

    localparam logic [CW-1:0] HIT_LOAD  = CW'(HIT_LATENCY - 1);
    localparam logic [CW-1:0] MISS_LOAD = CW'(MISS_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_e;
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BIDX-1:0]   blk_q, blk_d;
    logic              write_q, write_d;
    block_t            wdata_q, wdata_d;
    logic              row_hit_q, row_hit_d;
    logic              open_valid_q, open_valid_d;
    logic [BIDX-1:0]   open_blk_q, open_blk_d;
    block_t            rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              hit_q, hit_d;
    logic              commit;

    block_t            mem_array [MEM_BLOCKS];

    logic              req;
    logic [BIDX-1:0]   req_blk;
    logic              unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign req_blk          = mem_addr[OFF+BIDX-1:OFF];
    // Upper bits alias onto the same blocks; offset bits select nothing within a block access.
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFF+BIDX], mem_addr[OFF-1:0]};

    // NOTE: every *_d gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        row_hit_d    = row_hit_q;
        open_valid_d = open_valid_q;
        open_blk_d   = open_blk_q;
        rdata_d      = rdata_q;
        ready_d      = 1'b0;
        hit_d        = 1'b0;
        commit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    blk_d     = req_blk;
                    write_d   = mem_write;
                    wdata_d   = mem_wdata;
                    row_hit_d = open_valid_q && (req_blk == open_blk_q);
                    cnt_d     = (open_valid_q && (req_blk == open_blk_q)) ? HIT_LOAD : MISS_LOAD;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    ready_d      = ~row_hit_q;
                    hit_d        = row_hit_q;
                    open_blk_d   = blk_q;
                    open_valid_d = 1'b1;
                    if (write_q) begin
                        commit = 1'b1;
                    end else begin
                        rdata_d = mem_array[blk_q];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = DONE;
            DONE: begin
                // Wait for the L2 to drop its request level before accepting again.
                if (!req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            blk_q        <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            row_hit_q    <= 1'b0;
            open_valid_q <= 1'b0;
            open_blk_q   <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_q        <= blk_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            row_hit_q    <= row_hit_d;
            open_valid_q <= open_valid_d;
            open_blk_q   <= open_blk_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            hit_q        <= hit_d;
        end
    end

    // NOTE: the storage array has no reset; rst only gates the write so an aborted access never commits.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem_array[blk_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign mem_hit   = hit_q;
    assign mem_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_l2_backing_memory.sv
// Randomized self-checking bench for l2_backing_memory against a block-level reference
// model (storage array, open row, last returned block).
module tb_l2_backing_memory;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int BS  = 16;
    localparam int MB  = 256;
    localparam int ML  = 20;
    localparam int HL  = 4;
    localparam int OFF = 4;

    typedef logic [BS-1:0][DW-1:0] blk_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    blk_t          mem_wdata;
    logic          mem_read;
    logic          mem_write;
    blk_t          mem_rdata;
    logic          mem_ready;
    logic          mem_hit;
    logic          mem_busy;

    l2_backing_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS),
        .MEM_BLOCKS(MB), .MISS_LATENCY(ML), .HIT_LATENCY(HL)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_hit(mem_hit), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [BS*DW-1:0] got, input logic [BS*DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    blk_t model_mem [MB];
    bit   model_wr  [MB];
    bit   m_open_v;
    int   m_open_blk;
    blk_t m_last_rdata;

    function automatic blk_t pattern(input int base);
        blk_t b;
        for (int i = 0; i < BS; i++) b[i] = DW'(base + i);
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < BS; i++) b[i] = $urandom;
        return b;
    endfunction

    // One complete access: drive, wait for the pulse, check, hold, release.
    task automatic access(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input blk_t wd, input int hold, input string tag);
        int  b;
        bit  exp_hit;
        int  exp_lat;
        int  lat;
        int  extra;
        b       = int'((addr >> OFF) % MB);
        exp_hit = m_open_v && (m_open_blk == b);
        exp_lat = exp_hit ? HL : ML;

        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;

        lat = -1;
        for (int m = 0; m < 100; m++) begin
            @(negedge clk);
            if (mem_ready || mem_hit) begin
                lat = m;
                break;
            end
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".ready"}, mem_ready, !exp_hit);
        check({tag, ".hit"}, mem_hit, exp_hit);
        check({tag, ".busy"}, mem_busy, 1'b1);

        if (wr) begin
            model_mem[b] = wd;
            model_wr[b]  = 1'b1;
        end else begin
            m_last_rdata = model_mem[b];
        end
        m_open_v   = 1'b1;
        m_open_blk = b;
        check({tag, ".rdata"}, mem_rdata, m_last_rdata);

        extra = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (mem_ready || mem_hit) extra++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int h = 0; h < 2; h++) begin
            @(negedge clk);
            if (mem_ready || mem_hit) extra++;
        end
        check({tag, ".extra_pulses"}, extra, 0);
        check({tag, ".idle"}, mem_busy, 1'b0);
    endtask

    initial begin
        int pulses;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        m_open_v     = 1'b0;
        m_open_blk   = 0;
        m_last_rdata = '0;
        for (int i = 0; i < MB; i++) model_wr[i] = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset.ready", mem_ready, 1'b0);
        check("reset.hit", mem_hit, 1'b0);
        check("reset.busy", mem_busy, 1'b0);
        check("reset.rdata", mem_rdata, '0);
        rst = 1'b0;

        // Directed sequence
        access(1'b0, 1'b1, 32'h0000_0110, pattern(32'hB000), 0, "wr_blk11");
        access(1'b0, 1'b1, 32'h0000_0100, pattern(32'hA000), 0, "cold_wr_blk10");
        access(1'b1, 1'b0, 32'h0000_0105, '0, 1, "rd_blk10_hit");
        access(1'b1, 1'b0, 32'h0000_0110, '0, 0, "rd_blk11_miss");
        access(1'b1, 1'b0, 32'h0000_0100, '0, 0, "rd_blk10_miss");
        access(1'b1, 1'b1, 32'h0000_0300, pattern(32'hC300), 0, "rw_both_300");
        access(1'b1, 1'b0, 32'h0000_0300, '0, 0, "rd_after_both");

        // Reset in the middle of a miss write to blk 0x10
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 32'h0000_0100;
        mem_wdata = pattern(32'hDEAD0);
        pulses    = 0;
        for (int m = 0; m < 10; m++) begin
            @(negedge clk);
            if (mem_ready || mem_hit) pulses++;
        end
        rst       = 1'b1;
        mem_write = 1'b0;
        for (int m = 0; m < 2; m++) begin
            @(negedge clk);
            if (mem_ready || mem_hit) pulses++;
        end
        check("abort.busy", mem_busy, 1'b0);
        check("abort.rdata", mem_rdata, '0);
        rst = 1'b0;
        @(negedge clk);
        if (mem_ready || mem_hit) pulses++;
        check("abort.pulses", pulses, 0);
        m_open_v     = 1'b0;
        m_last_rdata = '0;
        access(1'b1, 1'b0, 32'h0000_0100, '0, 0, "rd_after_abort");

        // Randomized traffic over a small block pool, with address aliasing
        for (int n = 0; n < 40; n++) begin
            int            b;
            logic [AW-1:0] a;
            bit            do_wr;
            bit            both;
            b     = 32'h20 + int'($urandom_range(0, 5));
            a     = ($urandom & ~32'hFFF) | AW'(b << OFF) | AW'($urandom_range(0, BS - 1));
            do_wr = !model_wr[b] || ($urandom_range(0, 1) == 1);
            both  = do_wr && ($urandom_range(0, 3) == 0);
            access(both || !do_wr, do_wr, a, rand_blk(), int'($urandom_range(0, 2)),
                   do_wr ? "rand_wr" : "rand_rd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
